alu_sequencer: RTL and testbench

Control block that drives the `sel` input and operands of the registered 8-operation ALU and captures its result for the 7-segment display path. It sits between the button debouncer (`db_tick`) and the ALU/segment driver, replacing the plain select counter.
- **Manual mode:** each button tick advances one operation.
- **Auto mode:** the block sweeps all 8 operations, dwelling on each result for a programmable time.
- Operands are latched per step, so moving the switches mid-evaluation never corrupts a captured result.

---
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Drives the operation select and operands of a registered 8-operation ALU
//   and captures its result for the 7-segment display path. It sits between
//   the button debouncer and the ALU/segment driver.
//     - Manual mode: each button tick advances one operation.
//     - Auto mode: sweeps all 8 operations and holds each result for DWELL
//       cycles.
//   Operands are latched only on the edge that changes sel. Moving the
//   switches while a result is being evaluated therefore cannot corrupt the
//   captured value.
//
// Parameters
//   DWELL    cycles each result is held in auto mode (>= 1)
//   ALU_LAT  cycles from a sel/operand change to a valid alu_out (>= 1)
//
// Ports
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   btn_tick      in   1  one-cycle pulse from the debouncer
//   mode_auto     in   1  level: 1 = auto sweep, 0 = manual stepping
//   sw_data_1     in   4  operand A switches
//   sw_data_2     in   4  operand B switches
//   alu_out       in   8  ALU result
//   sel           out  3  operation select to the ALU
//   op_a          out  4  latched operand A to the ALU
//   op_b          out  4  latched operand B to the ALU
//   result        out  8  captured result to the display
//   result_valid  out  1  one-cycle pulse when result updates
//   sweep_done    out  1  one-cycle pulse with the sel=7 capture in auto mode
//   busy          out  1  high while waiting on the ALU or capturing
//
// All outputs are registered. The FSM computes the next value of every
// output combinationally, and one register stage holds them all.

module alu_sequencer #(
  parameter int DWELL   = 50_000_000,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_tick,
  input  logic       mode_auto,
  input  logic [3:0] sw_data_1,
  input  logic [3:0] sw_data_2,
  input  logic [7:0] alu_out,
  output logic [2:0] sel,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       sweep_done,
  output logic       busy
);

  // Counter widths. The wait counter counts 0..ALU_LAT-1. The dwell counter
  // is sized to hold DWELL itself, although it only ever reaches DWELL-1.
  localparam int WAIT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ALU_LAT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DWELL   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_nxt;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [DWELL_W-1:0]  dwell_cnt_nxt;

  logic [2:0]          sel_nxt;
  logic [3:0]          op_a_nxt;
  logic [3:0]          op_b_nxt;
  logic [7:0]          result_nxt;
  logic                result_valid_nxt;
  logic                sweep_done_nxt;
  logic                busy_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      dwell_cnt    <= '0;
      sel          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      dwell_cnt    <= dwell_cnt_nxt;
      sel          <= sel_nxt;
      op_a         <= op_a_nxt;
      op_b         <= op_b_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      sweep_done   <= sweep_done_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    dwell_cnt_nxt    = dwell_cnt;
    sel_nxt          = sel;
    op_a_nxt         = op_a;
    op_b_nxt         = op_b;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    sweep_done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        // Auto has priority over a coincident tick and always restarts the
        // sweep from operation 0.
        if (mode_auto) begin
          sel_nxt      = 3'd0;
          op_a_nxt     = sw_data_1;
          op_b_nxt     = sw_data_2;
          wait_cnt_nxt = '0;
          state_nxt    = ST_WAIT;
        end else if (btn_tick) begin
          sel_nxt      = sel + 3'd1;
          op_a_nxt     = sw_data_1;
          op_b_nxt     = sw_data_2;
          wait_cnt_nxt = '0;
          state_nxt    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Ticks are not queued while the ALU settles.
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_CAPTURE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_CAPTURE: begin
        result_nxt       = alu_out;
        result_valid_nxt = 1'b1;
        sweep_done_nxt   = mode_auto && (sel == 3'd7);
        // Leaving auto during WAIT/CAPTURE still completes this capture.
        if (mode_auto) begin
          dwell_cnt_nxt = '0;
          state_nxt     = ST_DWELL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_DWELL: begin
        if (!mode_auto) begin
          dwell_cnt_nxt = '0;
          state_nxt     = ST_IDLE;
        end else if (btn_tick || (dwell_cnt == DWELL_LAST)) begin
          // A tick skips the remainder of the dwell. sel wraps 7 -> 0
          // through the 3-bit increment.
          sel_nxt       = sel + 3'd1;
          op_a_nxt      = sw_data_1;
          op_b_nxt      = sw_data_2;
          dwell_cnt_nxt = '0;
          wait_cnt_nxt  = '0;
          state_nxt     = ST_WAIT;
        end else begin
          dwell_cnt_nxt = dwell_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // busy is registered, so it is derived from the state being entered.
    busy_nxt = (state_nxt == ST_WAIT) || (state_nxt == ST_CAPTURE);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int DWELL   = 4;
  localparam int ALU_LAT = 1;
  localparam int PERIOD  = ALU_LAT + 1 + DWELL;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_tick;
  logic       mode_auto;
  logic [3:0] sw_data_1;
  logic [3:0] sw_data_2;
  logic [7:0] alu_out;
  logic [2:0] sel;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] result;
  logic       result_valid;
  logic       sweep_done;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int m_sel;

  alu_sequencer #(.DWELL(DWELL), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick), .mode_auto(mode_auto),
    .sw_data_1(sw_data_1), .sw_data_2(sw_data_2), .alu_out(alu_out),
    .sel(sel), .op_a(op_a), .op_b(op_b), .result(result),
    .result_valid(result_valid), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered ALU stub: one cycle of latency.
  always_ff @(posedge clk) alu_out <= {1'b0, sel, op_a};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Each call lands mid-cycle: outputs are settled, and inputs set now are
  // sampled at the next rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] b;
    int rv_cnt;
    reset = 1'b1; btn_tick = 1'b0; mode_auto = 1'b0;
    sw_data_1 = 4'h0; sw_data_2 = 4'h0;
    repeat (3) next_cycle();
    checks++;
    if ({sel, op_a, op_b, result, result_valid, sweep_done, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_init: got sel=%0d a=%h b=%h r=%h rv=%b sd=%b busy=%b required all 0",
               sel, op_a, op_b, result, result_valid, sweep_done, busy);
    end
    reset = 1'b0;
    next_cycle();
    // Start a step, then reset while it is waiting on the ALU.
    sw_data_1 = 4'h7; sw_data_2 = 4'h9; btn_tick = 1'b1;
    next_cycle();
    btn_tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel !== 3'd1) begin
      errors++;
      $display("FAIL reset_pre_wait: got sel=%0d busy=%b required sel=1 busy=1", sel, busy);
    end
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
    checks++;
    if ({sel, op_a, op_b, result, result_valid, sweep_done, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: got sel=%0d a=%h b=%h r=%h rv=%b sd=%b busy=%b required all 0",
               sel, op_a, op_b, result, result_valid, sweep_done, busy);
    end
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (result_valid === 1'b1) rv_cnt++;
    end
    checks++;
    if (rv_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got %0d captures busy=%b required 0 captures busy=0", rv_cnt, busy);
    end
    // The first tick after reset selects operation 1.
    b = 4'($urandom);
    sw_data_1 = 4'h5; sw_data_2 = b; btn_tick = 1'b1;
    next_cycle();
    btn_tick = 1'b0;
    checks++;
    if (sel !== 3'd1 || op_a !== 4'h5 || op_b !== b || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_tick: got sel=%0d a=%h b=%h busy=%b required sel=1 a=5 b=%h busy=1",
               sel, op_a, op_b, busy, b);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (result !== 8'h15 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_result: got r=%h rv=%b required r=15 rv=1", result, result_valid);
    end
    m_sel = 1;
  endtask

  task automatic test_manual();
    logic [3:0] a, b;
    logic [2:0] exp_sel;
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      exp_sel = 3'((m_sel + 1) % 8);
      sw_data_1 = a; sw_data_2 = b; btn_tick = 1'b1;
      next_cycle();                                   // T+1
      btn_tick = 1'b0;
      checks++;
      if (sel !== exp_sel || op_a !== a || op_b !== b || busy !== 1'b1) begin
        errors++;
        $display("FAIL manual_select[%0d]: got sel=%0d a=%h b=%h busy=%b required sel=%0d a=%h b=%h busy=1",
                 i, sel, op_a, op_b, busy, exp_sel, a, b);
      end
      sw_data_1 = 4'($urandom); sw_data_2 = 4'($urandom);
      next_cycle();                                   // T+2
      checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL manual_wait[%0d]: got busy=%b rv=%b required busy=1 rv=0", i, busy, result_valid);
      end
      next_cycle();                                   // T+3
      checks++;
      if (result !== {1'b0, exp_sel, a} || result_valid !== 1'b1 ||
          sweep_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL manual_result[%0d]: got r=%h rv=%b sd=%b busy=%b required r=%h rv=1 sd=0 busy=0",
                 i, result, result_valid, sweep_done, busy, {1'b0, exp_sel, a});
      end
      m_sel = int'(exp_sel);
    end
    next_cycle();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual_pulse_width: got rv=%b required 0", result_valid);
    end
  endtask

  task automatic test_operand_freeze();
    logic [2:0] exp_sel;
    exp_sel = 3'((m_sel + 1) % 8);
    sw_data_1 = 4'h5; btn_tick = 1'b1;
    next_cycle();                                     // T+1
    btn_tick = 1'b0;
    next_cycle();                                     // T+2
    sw_data_1 = 4'hA;
    next_cycle();                                     // T+3
    checks++;
    if (result !== {1'b0, exp_sel, 4'h5} || result_valid !== 1'b1 || op_a !== 4'h5) begin
      errors++;
      $display("FAIL freeze_capture: got r=%h rv=%b a=%h required r=%h rv=1 a=5",
               result, result_valid, op_a, {1'b0, exp_sel, 4'h5});
    end
    m_sel = int'(exp_sel);
    exp_sel = 3'((m_sel + 1) % 8);
    btn_tick = 1'b1;
    next_cycle();
    btn_tick = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (result !== {1'b0, exp_sel, 4'hA} || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL freeze_next: got r=%h rv=%b required r=%h rv=1",
               result, result_valid, {1'b0, exp_sel, 4'hA});
    end
    m_sel = int'(exp_sel);
  endtask

  task automatic test_dropped_tick();
    logic [2:0] exp_sel;
    int rv_cnt, bad_sel;
    exp_sel = 3'((m_sel + 1) % 8);
    sw_data_1 = 4'($urandom); btn_tick = 1'b1;
    rv_cnt = 0; bad_sel = 0;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      btn_tick = (c <= 2);                            // extra ticks while busy
      if (sel !== exp_sel) bad_sel++;
      if (result_valid === 1'b1) rv_cnt++;
    end
    checks++;
    if (bad_sel !== 0) begin
      errors++;
      $display("FAIL dropped_sel: got %0d cycles with sel != %0d required 0", bad_sel, exp_sel);
    end
    checks++;
    if (rv_cnt !== 1) begin
      errors++;
      $display("FAIL dropped_rv: got %0d captures required 1", rv_cnt);
    end
    m_sel = int'(exp_sel);
  endtask

  task automatic test_auto_sweep();
    logic [3:0] hist [0:60];
    logic [2:0] exp_sel, exp_k;
    logic       exp_rv, exp_sd, exp_busy;
    sw_data_1 = 4'h3;
    hist[0] = 4'($urandom); sw_data_2 = hist[0];
    mode_auto = 1'b1;                                 // cycle 0
    for (int c = 1; c <= 51; c++) begin
      next_cycle();
      exp_sel  = 3'(((c - 1) / PERIOD) % 8);
      exp_rv   = (c >= 3) && ((c - 3) % PERIOD == 0);
      exp_k    = 3'(((c - 3) / PERIOD) % 8);
      exp_sd   = exp_rv && (exp_k == 3'd7);
      exp_busy = ((c - 1) % PERIOD) < (ALU_LAT + 1);
      checks++;
      if (sel !== exp_sel || result_valid !== exp_rv || sweep_done !== exp_sd || busy !== exp_busy) begin
        errors++;
        $display("FAIL auto_ctrl[c=%0d]: got sel=%0d rv=%b sd=%b busy=%b required sel=%0d rv=%b sd=%b busy=%b",
                 c, sel, result_valid, sweep_done, busy, exp_sel, exp_rv, exp_sd, exp_busy);
      end
      checks++;
      if (op_a !== 4'h3 || op_b !== hist[PERIOD * ((c - 1) / PERIOD)]) begin
        errors++;
        $display("FAIL auto_operands[c=%0d]: got a=%h b=%h required a=3 b=%h",
                 c, op_a, op_b, hist[PERIOD * ((c - 1) / PERIOD)]);
      end
      if (exp_rv) begin
        checks++;
        if (result !== {1'b0, exp_k, 4'h3}) begin
          errors++;
          $display("FAIL auto_result[c=%0d]: got %h required %h", c, result, {1'b0, exp_k, 4'h3});
        end
      end
      hist[c] = 4'($urandom); sw_data_2 = hist[c];
      if (c == 50) mode_auto = 1'b0;                  // leave auto during CAPTURE
    end
    for (int c = 52; c <= 54; c++) begin
      next_cycle();
      checks++;
      if (sel !== 3'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL auto_exit_idle[c=%0d]: got sel=%0d busy=%b rv=%b required sel=0 busy=0 rv=0",
                 c, sel, busy, result_valid);
      end
    end
    m_sel = 0;
  endtask

  task automatic test_skip_exit();
    logic [3:0] a1, a2;
    // Make sel non-zero so the auto-wins case is observable.
    btn_tick = 1'b1;
    next_cycle();
    btn_tick = 1'b0;
    repeat (2) next_cycle();
    m_sel = (m_sel + 1) % 8;
    checks++;
    if (sel !== 3'(m_sel)) begin
      errors++;
      $display("FAIL skip_setup: got sel=%0d required %0d", sel, m_sel);
    end
    // Tick and auto together in IDLE: auto wins.
    a1 = 4'($urandom); sw_data_1 = a1;
    btn_tick = 1'b1; mode_auto = 1'b1;                // T
    next_cycle();                                     // T+1
    btn_tick = 1'b0;
    checks++;
    if (sel !== 3'd0 || op_a !== a1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL skip_auto_wins: got sel=%0d a=%h busy=%b required sel=0 a=%h busy=1", sel, op_a, busy, a1);
    end
    next_cycle();                                     // T+2
    next_cycle();                                     // T+3 (DWELL)
    checks++;
    if (result !== {4'h0, a1} || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL skip_first: got r=%h rv=%b required r=%h rv=1", result, result_valid, {4'h0, a1});
    end
    a2 = 4'($urandom); sw_data_1 = a2;
    next_cycle();                                     // T+4 (DWELL)
    btn_tick = 1'b1;
    next_cycle();                                     // T+5
    btn_tick = 1'b0;
    checks++;
    if (sel !== 3'd1 || op_a !== a2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL skip_advance: got sel=%0d a=%h busy=%b required sel=1 a=%h busy=1", sel, op_a, busy, a2);
    end
    mode_auto = 1'b0;                                 // drop auto during WAIT
    next_cycle();                                     // T+6
    next_cycle();                                     // T+7
    checks++;
    if (result !== {1'b0, 3'd1, a2} || result_valid !== 1'b1 || sweep_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exit_capture: got r=%h rv=%b sd=%b busy=%b required r=%h rv=1 sd=0 busy=0",
               result, result_valid, sweep_done, busy, {1'b0, 3'd1, a2});
    end
    for (int c = 8; c <= 12; c++) begin
      next_cycle();
      checks++;
      if (sel !== 3'd1 || result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL exit_hold[T+%0d]: got sel=%0d rv=%b busy=%b required sel=1 rv=0 busy=0",
                 c, sel, result_valid, busy);
      end
    end
    // Dropping auto during DWELL returns to IDLE with sel held.
    sw_data_1 = 4'($urandom);
    mode_auto = 1'b1;                                 // T
    repeat (4) next_cycle();                          // T+4 (DWELL)
    mode_auto = 1'b0;
    for (int c = 5; c <= 10; c++) begin
      next_cycle();
      checks++;
      if (sel !== 3'd0 || result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dwell_exit[T+%0d]: got sel=%0d rv=%b busy=%b required sel=0 rv=0 busy=0",
                 c, sel, result_valid, busy);
      end
    end
    m_sel = 0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_operand_freeze();
    test_dropped_tick();
    test_auto_sweep();
    test_skip_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
